// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified memory arbiter.
// Grant ids, FSM states and latency bounds.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_LDR = 1'b1;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;
   localparam int CNT_W       = 3;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin picker for the memory arbiter.
// boot_hold locks arbitration to the loader port.
module mem_arb_rr_pick
   import mem_arb_pkg::*;
(
   input  logic cpuReq,
   input  logic ldrReq,
   input  logic lastGrant,
   input  logic bootHold,
   output logic gntValid,
   output logic gntId
);

   always_comb begin
      gntValid = 1'b0;
      gntId    = GNT_LDR;
      unique case (1'b1)
         bootHold: begin
            gntValid = ldrReq;
            gntId    = GNT_LDR;
         end
         !bootHold && cpuReq && ldrReq: begin
            gntValid = 1'b1;
            gntId    = (lastGrant == GNT_CPU) ? GNT_LDR : GNT_CPU;
         end
         !bootHold && cpuReq && !ldrReq: begin
            gntValid = 1'b1;
            gntId    = GNT_CPU;
         end
         !bootHold && !cpuReq && ldrReq: begin
            gntValid = 1'b1;
            gntId    = GNT_LDR;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the unified memory between the core (CPU) and the loader.
// Each access runs IDLE -> ISSUE -> WAIT x MEM_LAT -> RESP.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_ready,
   input  logic              boot_hold,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Out-of-range latencies are clamped to the supported window
   localparam int LAT =
      (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
      (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t            state;
   state_t            stateNext;
   logic              gnt;
   logic              lastGrant;
   logic              weQ;
   logic [ADDR_W-1:0] addrQ;
   logic [DATA_W-1:0] wdataQ;
   logic [DATA_W-1:0] cpuRdQ;
   logic [DATA_W-1:0] ldrRdQ;
   logic [CNT_W-1:0]  cnt;
   logic              pickValid;
   logic              pickId;
   logic              take;
   logic              capture;

   mem_arb_rr_pick uPick (
      .cpuReq   (cpu_req),
      .ldrReq   (ldr_req),
      .lastGrant(lastGrant),
      .bootHold (boot_hold),
      .gntValid (pickValid),
      .gntId    (pickId)
   );

   always_comb begin
      stateNext = state;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (pickValid) begin
               stateNext = ISSUE;
               take      = 1'b1;
            end
         end
         ISSUE: stateNext = WAIT;
         WAIT: begin
            if (cnt == ONE) stateNext = RESP;
         end
         RESP: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign capture = (state == WAIT) && (cnt == ONE) && !weQ;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         gnt       <= GNT_CPU;
         lastGrant <= GNT_LDR;
         weQ       <= 1'b0;
         addrQ     <= '0;
         wdataQ    <= '0;
         cpuRdQ    <= '0;
         ldrRdQ    <= '0;
         cnt       <= '0;
      end else begin
         state <= stateNext;
         if (take) begin
            gnt       <= pickId;
            lastGrant <= pickId;
            if (pickId == GNT_CPU) begin
               weQ    <= cpu_we;
               addrQ  <= cpu_addr;
               wdataQ <= cpu_wdata;
            end else begin
               weQ    <= ldr_we;
               addrQ  <= ldr_addr;
               wdataQ <= ldr_wdata;
            end
         end
         if (state == ISSUE) cnt <= LAT_CNT;
         else if (state == WAIT) cnt <= cnt - ONE;
         if (capture && gnt == GNT_CPU) cpuRdQ <= mem_rdata;
         if (capture && gnt == GNT_LDR) ldrRdQ <= mem_rdata;
      end
   end

   assign mem_en    = (state == ISSUE);
   assign mem_we    = (state == ISSUE) && weQ;
   assign mem_addr  = addrQ;
   assign mem_wdata = wdataQ;
   assign cpu_rdata = cpuRdQ;
   assign ldr_rdata = ldrRdQ;
   assign cpu_ready = (state == RESP) && (gnt == GNT_CPU);
   assign ldr_ready = (state == RESP) && (gnt == GNT_LDR);
   // Held low while reset is asserted so every output reads zero
   assign cpu_stall = reset && cpu_req && !cpu_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter (MEM_LAT=1 and MEM_LAT=3).
// Uses a word-array memory model and a transaction-level reference.
module tb_unified_mem_arbiter;

   localparam int L1 = 1;
   localparam int L3 = 3;

   logic clk = 1'b0;
   logic rstN;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        cpuReq, cpuWe, ldrReq, ldrWe, bootHold;
   logic [31:0] cpuAddr, cpuWdata, ldrAddr, ldrWdata;
   logic [31:0] cpuRdata, ldrRdata, memAddr, memWdata, memRdata;
   logic        cpuReady, cpuStall, ldrReady, memEn, memWe;

   logic        bCpuReq, bCpuWe, bLdrReq, bLdrWe, bBoot;
   logic [31:0] bCpuAddr, bCpuWdata, bLdrAddr, bLdrWdata;
   logic [31:0] bCpuRdata, bLdrRdata, bMemAddr, bMemWdata;
   logic [31:0] bMemRdata;
   logic        bCpuReady, bCpuStall, bLdrReady, bMemEn, bMemWe;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L1)) dut1 (
      .clk(clk), .reset(rstN),
      .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr),
      .cpu_wdata(cpuWdata), .cpu_rdata(cpuRdata),
      .cpu_ready(cpuReady), .cpu_stall(cpuStall),
      .ldr_req(ldrReq), .ldr_we(ldrWe), .ldr_addr(ldrAddr),
      .ldr_wdata(ldrWdata), .ldr_rdata(ldrRdata),
      .ldr_ready(ldrReady), .boot_hold(bootHold),
      .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr),
      .mem_wdata(memWdata), .mem_rdata(memRdata)
   );

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L3)) dut3 (
      .clk(clk), .reset(rstN),
      .cpu_req(bCpuReq), .cpu_we(bCpuWe), .cpu_addr(bCpuAddr),
      .cpu_wdata(bCpuWdata), .cpu_rdata(bCpuRdata),
      .cpu_ready(bCpuReady), .cpu_stall(bCpuStall),
      .ldr_req(bLdrReq), .ldr_we(bLdrWe), .ldr_addr(bLdrAddr),
      .ldr_wdata(bLdrWdata), .ldr_rdata(bLdrRdata),
      .ldr_ready(bLdrReady), .boot_hold(bBoot),
      .mem_en(bMemEn), .mem_we(bMemWe), .mem_addr(bMemAddr),
      .mem_wdata(bMemWdata), .mem_rdata(bMemRdata)
   );

   // Memory models: data valid only in the single cycle that is
   // MEM_LAT cycles after the issue edge, junk otherwise.
   logic [31:0] memA [0:255];
   logic [31:0] memB [0:255];
   logic        memClr, bdEn;
   logic [31:0] bdAddr, bdData;
   logic [15:0] cyc;
   logic        v1;
   logic [31:0] d1;
   logic [2:0]  v3;
   logic [31:0] d3a, d3b, d3c;
   logic [31:0] junk;

   always @(posedge clk) begin
      if (memClr) begin
         cyc <= '0;
         for (int i = 0; i < 256; i++) begin
            memA[i] <= '0;
            memB[i] <= '0;
         end
      end else begin
         cyc <= cyc + 16'd1;
         if (bdEn) memA[bdAddr[9:2]] <= bdData;
         if (memEn && memWe) memA[memAddr[9:2]] <= memWdata;
         if (bMemEn && bMemWe) memB[bMemAddr[9:2]] <= bMemWdata;
      end
      v1  <= memEn & ~memWe;
      d1  <= memA[memAddr[9:2]];
      v3  <= {v3[1:0], bMemEn & ~bMemWe};
      d3a <= memB[bMemAddr[9:2]];
      d3b <= d3a;
      d3c <= d3b;
   end

   assign junk      = {16'h5A5A, cyc};
   assign memRdata  = v1 ? d1 : junk;
   assign bMemRdata = v3[2] ? d3c : junk;

   // Transaction-level reference
   logic [31:0] refMem [0:255];
   logic [31:0] refCpuRd, refLdrRd, ref3;
   int          refLast;

   task automatic ref_reset();
      refCpuRd = '0;
      refLdrRd = '0;
      refLast  = 1;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      bdAddr = a;
      bdData = d;
      bdEn   = 1'b1;
      refMem[a[9:2]] = d;
      @(posedge clk);
      #1 bdEn = 1'b0;
   endtask

   // Called at the start of an IDLE cycle; serves one access.
   task automatic do_access();
      int          port;
      int          done;
      logic        we;
      logic [31:0] a, wd;
      logic        eCr, eLr;
      if (bootHold) port = ldrReq ? 1 : -1;
      else if (cpuReq && ldrReq) port = (refLast == 1) ? 0 : 1;
      else if (cpuReq) port = 0;
      else if (ldrReq) port = 1;
      else port = -1;
      if (port < 0) return;
      we   = (port == 0) ? cpuWe : ldrWe;
      a    = (port == 0) ? cpuAddr : ldrAddr;
      wd   = (port == 0) ? cpuWdata : ldrWdata;
      done = 2 + L1;
      for (int c = 0; c <= done; c++) begin
         @(negedge clk);
         if (c == done) begin
            if (we) refMem[a[9:2]] = wd;
            else if (port == 0) refCpuRd = refMem[a[9:2]];
            else refLdrRd = refMem[a[9:2]];
         end
         eCr = (port == 0) && (c == done);
         eLr = (port == 1) && (c == done);
         checks++;
         if (memEn !== (c == 1)) begin
            errors++;
            $display("FAIL mem_en c=%0d: got %b want %b",
                     c, memEn, (c == 1));
         end
         if (c == 1) begin
            checks++;
            if ({memWe, memAddr} !== {we, a}) begin
               errors++;
               $display("FAIL mem_we/addr: got %b/%h want %b/%h",
                        memWe, memAddr, we, a);
            end
            if (we) begin
               checks++;
               if (memWdata !== wd) begin
                  errors++;
                  $display("FAIL mem_wdata: got %h want %h",
                           memWdata, wd);
               end
            end
         end
         checks++;
         if ({cpuReady, ldrReady} !== {eCr, eLr}) begin
            errors++;
            $display("FAIL ready c=%0d: got %b%b want %b%b",
                     c, cpuReady, ldrReady, eCr, eLr);
         end
         checks++;
         if (cpuStall !== (cpuReq && !eCr)) begin
            errors++;
            $display("FAIL cpu_stall c=%0d: got %b want %b",
                     c, cpuStall, (cpuReq && !eCr));
         end
         checks++;
         if (cpuRdata !== refCpuRd || ldrRdata !== refLdrRd) begin
            errors++;
            $display("FAIL rdata c=%0d: got %h/%h want %h/%h",
                     c, cpuRdata, ldrRdata, refCpuRd, refLdrRd);
         end
      end
      refLast = port;
      @(posedge clk);
      #1;
      if (port == 0) cpuReq = 1'b0;
      else ldrReq = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 memClr = 1'b0;
      @(negedge clk);
      checks++;
      if ({memEn, memWe, memAddr, memWdata} !== 66'd0) begin
         errors++;
         $display("FAIL reset mem bus: got %b %b %h %h",
                  memEn, memWe, memAddr, memWdata);
      end
      checks++;
      if ({cpuRdata, ldrRdata, bCpuRdata, bLdrRdata} !== 128'd0) begin
         errors++;
         $display("FAIL reset rdata: got %h %h want 0",
                  cpuRdata, ldrRdata);
      end
      checks++;
      if ({cpuReady, ldrReady, cpuStall, bCpuReady, bMemEn} !== 5'd0)
      begin
         errors++;
         $display("FAIL reset ctrl: got %b%b%b%b%b want 0",
                  cpuReady, ldrReady, cpuStall, bCpuReady, bMemEn);
      end
      @(posedge clk);
      #1 rstN = 1'b1;
      @(negedge clk);
      checks++;
      if ({memEn, cpuReady, ldrReady, cpuStall} !== 4'd0) begin
         errors++;
         $display("FAIL idle after reset: got %b%b%b%b want 0000",
                  memEn, cpuReady, ldrReady, cpuStall);
      end
   endtask

   task automatic test_basic_read();
      preload(32'h10, 32'hDEADBEEF);
      cpuReq = 1'b1;
      cpuWe  = 1'b0;
      cpuAddr = 32'h10;
      do_access();
      checks++;
      if (cpuRdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL basic cpu_rdata: got %h want deadbeef",
                  cpuRdata);
      end
   endtask

   task automatic test_ldr_then_cpu();
      ldrReq   = 1'b1;
      ldrWe    = 1'b1;
      ldrAddr  = 32'h40;
      ldrWdata = 32'h00000013;
      do_access();
      cpuReq  = 1'b1;
      cpuWe   = 1'b0;
      cpuAddr = 32'h40;
      do_access();
      checks++;
      if (cpuRdata !== 32'h13 || ldrRdata !== 32'h0) begin
         errors++;
         $display("FAIL ldr->cpu: got cpu %h ldr %h want 13 0",
                  cpuRdata, ldrRdata);
      end
   endtask

   task automatic test_round_robin();
      rstN = 1'b0;
      ref_reset();
      @(posedge clk);
      #1 rstN = 1'b1;
      cpuReq = 1'b1;  cpuWe = 1'b0;  cpuAddr = 32'h10;
      ldrReq = 1'b1;  ldrWe = 1'b0;  ldrAddr = 32'h40;
      for (int k = 0; k < 4; k++) begin
         do_access();
         checks++;
         if (refLast != (k % 2)) begin
            errors++;
            $display("FAIL rr order k=%0d: got %0d want %0d",
                     k, refLast, k % 2);
         end
         if (!cpuReq) begin
            cpuReq = 1'b1;
            cpuAddr = 32'($urandom_range(0, 255)) << 2;
         end
         if (!ldrReq) begin
            ldrReq = 1'b1;
            ldrAddr = 32'($urandom_range(0, 255)) << 2;
         end
      end
      while (cpuReq || ldrReq) do_access();
   endtask

   task automatic test_boot_hold();
      bootHold = 1'b1;
      cpuReq = 1'b1;  cpuWe = 1'b0;  cpuAddr = 32'h84;
      for (int k = 0; k < 3; k++) begin
         ldrReq   = 1'b1;
         ldrWe    = 1'b1;
         ldrAddr  = 32'h80 + 32'(4 * k);
         ldrWdata = $urandom;
         do_access();
         checks++;
         if (refLast != 1) begin
            errors++;
            $display("FAIL boot grant k=%0d: got %0d want 1",
                     k, refLast);
         end
      end
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (memEn !== 1'b0 || cpuStall !== 1'b1) begin
            errors++;
            $display("FAIL boot lockout: got en %b stall %b want 0 1",
                     memEn, cpuStall);
         end
      end
      @(posedge clk);
      #1 bootHold = 1'b0;
      do_access();
      checks++;
      if (cpuRdata !== refMem[33]) begin
         errors++;
         $display("FAIL boot cpu read: got %h want %h",
                  cpuRdata, refMem[33]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         if (!cpuReq && ($urandom % 2 == 0)) begin
            cpuReq   = 1'b1;
            cpuWe    = 1'($urandom % 2);
            cpuAddr  = 32'($urandom_range(0, 255)) << 2;
            cpuWdata = $urandom;
         end
         if (!ldrReq && ($urandom % 2 == 0)) begin
            ldrReq   = 1'b1;
            ldrWe    = 1'($urandom % 2);
            ldrAddr  = 32'($urandom_range(0, 255)) << 2;
            ldrWdata = $urandom;
         end
         if (!cpuReq && !ldrReq) begin
            cpuReq  = 1'b1;
            cpuWe   = 1'b0;
            cpuAddr = 32'($urandom_range(0, 255)) << 2;
         end
         bootHold = ldrReq && ($urandom % 4 == 0);
         do_access();
      end
      bootHold = 1'b0;
      while (cpuReq || ldrReq) do_access();
   endtask

   task automatic test_reset_mid();
      cpuReq  = 1'b1;
      cpuWe   = 1'b0;
      cpuAddr = 32'($urandom_range(0, 255)) << 2;
      repeat (3) @(negedge clk);
      #2 rstN = 1'b0;
      ref_reset();
      #1;
      checks++;
      if ({memEn, memWe, memAddr, memWdata} !== 66'd0) begin
         errors++;
         $display("FAIL mid reset bus: got %b %b %h %h",
                  memEn, memWe, memAddr, memWdata);
      end
      checks++;
      if ({cpuRdata, ldrRdata, cpuReady, ldrReady} !== 66'd0) begin
         errors++;
         $display("FAIL mid reset out: got %h %h %b %b",
                  cpuRdata, ldrRdata, cpuReady, ldrReady);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({cpuReady, ldrReady, memEn} !== 3'd0) begin
            errors++;
            $display("FAIL ready in reset: got %b%b%b want 000",
                     cpuReady, ldrReady, memEn);
         end
      end
      @(posedge clk);
      #1 rstN = 1'b1;
      do_access();
   endtask

   task automatic test_latency3();
      logic [31:0] a, wd;
      ref3 = '0;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) begin
            a  = 32'($urandom_range(0, 255)) << 2;
            wd = $urandom;
         end
         bCpuReq   = 1'b1;
         bCpuWe    = (k % 2 == 0);
         bCpuAddr  = a;
         bCpuWdata = wd;
         for (int c = 0; c <= 2 + L3; c++) begin
            @(negedge clk);
            if (c == 2 + L3 && !bCpuWe) ref3 = wd;
            checks++;
            if (bMemEn !== (c == 1)) begin
               errors++;
               $display("FAIL lat3 mem_en c=%0d: got %b", c, bMemEn);
            end
            checks++;
            if (bCpuReady !== (c == 2 + L3) ||
                bCpuStall !== (c != 2 + L3)) begin
               errors++;
               $display("FAIL lat3 ready/stall c=%0d: got %b %b",
                        c, bCpuReady, bCpuStall);
            end
            checks++;
            if (bCpuRdata !== ref3) begin
               errors++;
               $display("FAIL lat3 rdata c=%0d: got %h want %h",
                        c, bCpuRdata, ref3);
            end
         end
         @(posedge clk);
         #1 bCpuReq = 1'b0;
      end
   endtask

   initial begin
      rstN = 1'b0;
      memClr = 1'b1;
      bdEn = 1'b0;  bdAddr = '0;  bdData = '0;
      cpuReq = 1'b0;  cpuWe = 1'b0;  cpuAddr = '0;  cpuWdata = '0;
      ldrReq = 1'b0;  ldrWe = 1'b0;  ldrAddr = '0;  ldrWdata = '0;
      bootHold = 1'b0;
      bCpuReq = 1'b0;  bCpuWe = 1'b0;  bCpuAddr = '0;  bCpuWdata = '0;
      bLdrReq = 1'b0;  bLdrWe = 1'b0;  bLdrAddr = '0;  bLdrWdata = '0;
      bBoot = 1'b0;
      for (int i = 0; i < 256; i++) refMem[i] = '0;
      ref_reset();
      ref3 = '0;
      test_reset();
      test_basic_read();
      test_ldr_then_cpu();
      test_round_robin();
      test_boot_hold();
      test_random();
      test_reset_mid();
      test_latency3();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Arbitrates the single unified instruction/data memory of the multicycle RISC-V core between two requesters: the core's control path (CPU port) and the program loader (LDR port).
- Sequences each access as issue → wait for memory latency → respond.
- Returns a stall to the multicycle FSM so it holds its current state until the access completes.
- Sits between the FSM/datapath memory signals (MemRead/MemWrite/IorD address) and the memory block.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, memory read latency in cycles after the issue edge; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request (MemRead|MemWrite); held until cpu_ready
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU access address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, registered
cpu_ready  out  1  one-cycle completion pulse to CPU
cpu_stall  out  1  to FSM: hold state while access pending
ldr_req  in  1  loader request; held until ldr_ready
ldr_we  in  1  loader write enable
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_rdata  out  DATA_W  loader read data, registered
ldr_ready  out  1  one-cycle completion pulse to loader
boot_hold  in  1  1 = loader-exclusive mode; CPU is never granted
mem_en  out  1  memory enable, one cycle per access
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the issue edge

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, last_grant=LDR.
  - All outputs 0, including both rdata registers.
  - Any in-flight access is aborted with no ready pulse. A write whose ISSUE edge has not yet occurred is not committed.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE arbitration:
  - boot_hold=1: grant LDR if ldr_req, otherwise stay in IDLE.
  - boot_hold=0, one requester active: grant it.
  - boot_hold=0, both active: round-robin; grant the port that is not last_grant.
  - On grant: latch grant id, we, addr and wdata into mem_* registers, update last_grant, go to ISSUE.
- ISSUE: mem_en=1 and mem_we=latched we for exactly one cycle, then go to WAIT with cnt=MEM_LAT.
- WAIT:
  - Decrement cnt each cycle.
  - At cnt=1, capture mem_rdata into the granted port's rdata (reads only; writes leave rdata unchanged), then go to RESP.
- RESP: pulse the granted port's ready for one cycle, then go to IDLE.
- Latency: req seen in IDLE at cycle 0 → mem_en at cycle 1 → ready at cycle 2+MEM_LAT. Every access is followed by one dead IDLE cycle; no back-to-back issue.
- Requester contract:
  - Hold req and payload stable until ready.
  - Deassert req (or present a new access) in the cycle after ready.
  - Payload is latched at grant, so changes after grant do not affect the in-flight access.
- cpu_stall = cpu_req & ~cpu_ready (combinational). It is 1 during IDLE wait, ISSUE, WAIT and any boot_hold lock-out.
- boot_hold or either req changing mid-access: no preemption; takes effect at the next IDLE.
- Ready and rdata go only to the granted port; the other port's outputs are unchanged.
- mem_addr/mem_wdata hold their last value outside ISSUE; mem_en=mem_we=0 outside ISSUE.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - grant ids GNT_CPU=0, GNT_LDR=1
  - MEM_LAT range limits
- Sub-module mem_arb_rr_pick:
  - 2-way round-robin picker with boot_hold override.
  - Inputs: both reqs, last_grant, boot_hold.
  - Outputs: grant valid and grant id (combinational).

Test Plan:
1. MEM_LAT=1; CPU read addr 0x10, memory holds 0xDEADBEEF → mem_en=1 in cycle 1 with mem_we=0 and mem_addr=0x10; cpu_ready in cycle 3; cpu_rdata=0xDEADBEEF; cpu_stall=1 in cycles 0–2, 0 in cycle 3.
2. Both request after reset, boot_hold=0 → CPU granted first, then LDR, then CPU (alternating); each ready pulse only on its own port.
3. boot_hold=1 with both requesting; loader writes 3 words → 3 LDR grants, cpu_stall stays 1. Drop boot_hold → CPU granted at the next IDLE.
4. Loader writes 0x00000013 to 0x40, then CPU reads 0x40 → cpu_rdata=0x00000013; ldr_rdata unchanged (0).
5. Pull reset low during WAIT → all outputs 0 immediately, no ready pulse. Release with cpu_req still high → access restarts from IDLE and completes normally.
6. MEM_LAT=3; CPU read → cpu_ready in cycle 5; mem_rdata is captured only at the end of the third WAIT cycle.
